// File: rtl/axis_slew_limiter_pkg.sv
// Shared types and default widths for the slew limiter and its tick generator.
package axis_slew_limiter_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_STEP_WIDTH     = 24;
  localparam int DEFAULT_PRESCALE_WIDTH = 16;

  typedef enum logic {
    HOLD = 1'b0,
    RAMP = 1'b1
  } slew_state_t;

endpackage

// File: rtl/slew_tick_gen.sv
// Programmable tick divider: one-cycle tick every prescale+1 cycles.
module slew_tick_gen
  import axis_slew_limiter_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      a_clk,
  input  logic                      a_rst,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  logic [PRESCALE_WIDTH-1:0] cnt;

  // >= rather than == so that lowering prescale below cnt wraps immediately.
  assign tick = (cnt >= prescale);

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PRESCALE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_slew_limiter.sv
// Ramps the output toward the latched target by at most one step per tick.
module axis_slew_limiter
  import axis_slew_limiter_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int STEP_WIDTH     = DEFAULT_STEP_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      a_clk,
  input  logic                      a_rst,
  input  logic [DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                      S_AXIS_tvalid,
  input  logic [STEP_WIDTH-1:0]     step,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic [DATA_WIDTH-1:0]     M_AXIS_tdata,
  output logic                      M_AXIS_tvalid,
  output logic                      busy
);

  localparam int EXT_WIDTH = DATA_WIDTH + 1;

  slew_state_t                 state_q, state_next;
  logic [DATA_WIDTH-1:0]       target_q, out_q, out_next;
  logic                        valid_q;
  logic                        tick;
  logic signed [EXT_WIDTH-1:0] diff, mag, step_ext;
  logic [DATA_WIDTH-1:0]       step_dw;

  slew_tick_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_tick (
    .a_clk   (a_clk),
    .a_rst   (a_rst),
    .prescale(prescale),
    .tick    (tick)
  );

  // One extra bit keeps the difference exact across the full signed range.
  assign diff     = $signed({target_q[DATA_WIDTH-1], target_q}) - $signed({out_q[DATA_WIDTH-1], out_q});
  assign mag      = diff[EXT_WIDTH-1] ? -diff : diff;
  assign step_ext = EXT_WIDTH'(step);
  assign step_dw  = DATA_WIDTH'(step);

  always_comb begin
    state_next = HOLD;
    out_next   = out_q;
    if (out_q != target_q) begin
      state_next = RAMP;
    end
    if (tick && state_q == RAMP) begin
      if (step == '0 || mag <= step_ext) begin
        out_next = target_q;
      end else begin
        // Only reached when |diff| > step, so the stepped value cannot wrap.
        out_next = diff[EXT_WIDTH-1] ? (out_q - step_dw) : (out_q + step_dw);
      end
    end
  end

  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q  <= HOLD;
      target_q <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q <= state_next;
      out_q   <= out_next;
      valid_q <= 1'b1;
      if (S_AXIS_tvalid) begin
        target_q <= S_AXIS_tdata;
      end
    end
  end

  assign M_AXIS_tdata  = out_q;
  assign M_AXIS_tvalid = valid_q;
  assign busy          = (state_q == RAMP);

endmodule
